// File: rtl/mem_arbiter.sv
// Arbitrates I-side and D-side requests onto one single-port memory, with an abort watchdog.
// Define ARB_ROUND_ROBIN_EN for round-robin on simultaneous requests; default is fixed D-side priority.
module mem_arbiter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_req,
  input  logic [WIDTH-1:0] i_addr,
  output logic             i_done,
  output logic [WIDTH-1:0] i_rdata,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [3:0]       d_be,
  input  logic [WIDTH-1:0] d_addr,
  input  logic [WIDTH-1:0] d_wdata,
  output logic             d_done,
  output logic [WIDTH-1:0] d_rdata,
  output logic             mem_req,
  output logic             mem_we,
  output logic [3:0]       mem_be,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             busy,
  output logic             err
);

  localparam int unsigned TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;
  typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_t;

  state_t           r_state, w_state;
  owner_t           r_owner, w_owner;
  owner_t           r_last, w_last;
  logic [TW-1:0]    r_timer, w_timer;
  logic             r_mem_req, w_mem_req;
  logic             r_mem_we, w_mem_we;
  logic [3:0]       r_mem_be, w_mem_be;
  logic [WIDTH-1:0] r_mem_addr, w_mem_addr;
  logic [WIDTH-1:0] r_mem_wdata, w_mem_wdata;
  logic             r_i_done, w_i_done;
  logic             r_d_done, w_d_done;
  logic [WIDTH-1:0] r_i_rdata, w_i_rdata;
  logic [WIDTH-1:0] r_d_rdata, w_d_rdata;
  logic             r_busy, w_busy;
  logic             r_err, w_err;
  logic             w_pick_d;

  // Winner selection when idle; a lone requester always wins.
`ifdef ARB_ROUND_ROBIN_EN
  assign w_pick_d = (i_req && d_req) ? (r_last == OWN_I) : d_req;
`else
  assign w_pick_d = d_req;
`endif

  always_comb begin
    w_state     = r_state;
    w_owner     = r_owner;
    w_last      = r_last;
    w_timer     = r_timer;
    w_mem_req   = r_mem_req;
    w_mem_we    = r_mem_we;
    w_mem_be    = r_mem_be;
    w_mem_addr  = r_mem_addr;
    w_mem_wdata = r_mem_wdata;
    w_i_done    = r_i_done;
    w_d_done    = r_d_done;
    w_i_rdata   = r_i_rdata;
    w_d_rdata   = r_d_rdata;
    w_err       = r_err;

    unique case (r_state)
      S_IDLE: begin
        if (i_req || d_req) begin
          w_owner     = w_pick_d ? OWN_D : OWN_I;
          w_mem_req   = 1'b1;
          w_mem_we    = w_pick_d ? d_we : 1'b0;
          w_mem_be    = w_pick_d ? d_be : 4'hF;
          w_mem_addr  = w_pick_d ? d_addr : i_addr;
          w_mem_wdata = w_pick_d ? d_wdata : '0;
          w_timer     = '0;
          w_state     = S_BUSY;
        end
      end
      S_BUSY: begin
        if (mem_ack) begin
          w_mem_req = 1'b0;
          if (r_owner == OWN_D) begin
            w_d_done = 1'b1;
            if (!r_mem_we) w_d_rdata = mem_rdata;
          end else begin
            w_i_done  = 1'b1;
            w_i_rdata = mem_rdata;
          end
          w_state = S_RESP;
        end else if (r_timer == TW'(TIMEOUT - 1)) begin
          // Memory never answered: abort with err, read data left untouched.
          w_mem_req = 1'b0;
          w_err     = 1'b1;
          if (r_owner == OWN_D) w_d_done = 1'b1;
          else                  w_i_done = 1'b1;
          w_state = S_RESP;
        end else begin
          w_timer = r_timer + TW'(1);
        end
      end
      S_RESP: begin
        w_i_done = 1'b0;
        w_d_done = 1'b0;
        w_err    = 1'b0;
        w_last   = r_owner;
        w_state  = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase

    w_busy = (w_state != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_owner     <= OWN_I;
      r_last      <= OWN_I;
      r_timer     <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_be    <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_i_done    <= 1'b0;
      r_d_done    <= 1'b0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_owner     <= w_owner;
      r_last      <= w_last;
      r_timer     <= w_timer;
      r_mem_req   <= w_mem_req;
      r_mem_we    <= w_mem_we;
      r_mem_be    <= w_mem_be;
      r_mem_addr  <= w_mem_addr;
      r_mem_wdata <= w_mem_wdata;
      r_i_done    <= w_i_done;
      r_d_done    <= w_d_done;
      r_i_rdata   <= w_i_rdata;
      r_d_rdata   <= w_d_rdata;
      r_busy      <= w_busy;
      r_err       <= w_err;
    end
  end

  assign i_done    = r_i_done;
  assign i_rdata   = r_i_rdata;
  assign d_done    = r_d_done;
  assign d_rdata   = r_d_rdata;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_be    = r_mem_be;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = r_busy;
  assign err       = r_err;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter sharing one single-port backing memory between the instruction-side refill path and the data-side cache refill/writeback path of the 5-stage RV32I core. Each requester issues one transaction at a time via a req/done handshake; the arbiter registers the winner's request onto the memory port, waits for the memory acknowledge (variable latency), and returns read data with a one-cycle done pulse. A watchdog aborts transactions the memory never acknowledges.

## Interface
- WIDTH, 32, address and data width
- TIMEOUT, 64, max cycles mem_req may stay high without mem_ack before abort (≥2)

- clk  input  1  clock, rising edge
- rst  input  1  asynchronous active-low reset (asserted when 0)
- i_req  input  1  instruction-side request, held until i_done
- i_addr  input  WIDTH  instruction-side word address (read only)
- i_done  output  1  one-cycle completion pulse, instruction side
- i_rdata  output  WIDTH  instruction-side read data, valid when i_done=1
- d_req  input  1  data-side request, held until d_done
- d_we  input  1  data-side write enable
- d_be  input  4  data-side byte enables (writes only)
- d_addr  input  WIDTH  data-side address
- d_wdata  input  WIDTH  data-side write data
- d_done  output  1  one-cycle completion pulse, data side
- d_rdata  output  WIDTH  data-side read data, valid when d_done=1 and d_we was 0
- mem_req  output  1  memory request, held until mem_ack
- mem_we, mem_be, mem_addr, mem_wdata  output  1/4/WIDTH/WIDTH  registered request fields
- mem_ack  input  1  memory completion, single cycle
- mem_rdata  input  WIDTH  memory read data, valid with mem_ack
- busy  output  1  high in any state other than IDLE
- err  output  1  high together with a done pulse when that transaction timed out

## Operation
- States: IDLE, BUSY, RESP.
- IDLE: if any req, pick winner, register its fields into mem_* (I-side: mem_we=0, mem_be=4'hF), set mem_req=1, load owner, clear timer, → BUSY. No req: stay.
- Arbitration, both requesting: see Configuration. Single requester always wins.
- BUSY: mem_* fields frozen. On mem_ack: mem_req=0; owner's rdata ← mem_rdata if read (unchanged on write); owner's done=1; → RESP. Timer increments each BUSY cycle without ack; on reaching TIMEOUT-1: mem_req=0, owner's done=1, err=1, rdata unchanged, → RESP.
- RESP: done and err cleared; record last owner; → IDLE. Requests ignored in RESP.
- Requester must drop req on the cycle after its done pulse unless issuing a new transaction; a req still high in the following IDLE is a new transaction.
- req/fields changing while BUSY have no effect; mem_ack in IDLE/RESP is ignored.
- Reset (any state, async): all outputs and state registers to 0 immediately (mem_req, mem_we, mem_be, mem_addr, mem_wdata, i_done, d_done, i_rdata, d_rdata, busy, err = 0), state IDLE, last owner = I-side. No done issued for an aborted transaction.

## Timing
- All outputs registered; no combinational path from inputs to outputs.
- req high at edge N → mem_req high from edge N+1.
- mem_ack at edge M → done high for exactly cycle M+1..M+2; earliest next mem_req at edge M+3.
- Minimum turnaround with single-cycle memory (ack at N+2): done at N+3, 4 cycles per transaction.
- Timeout: err+done asserted TIMEOUT cycles after mem_req rose.

## Configuration
- ARB_ROUND_ROBIN_EN defined: on simultaneous requests, grant the side not recorded as last owner; each side guaranteed service within one other transaction.
- Undefined: fixed priority, data side always wins simultaneous requests (I-side may starve under continuous d_req).

## Test plan
- Single I read, mem_ack 3 cycles after mem_req, mem_rdata=32'h0000_0013 -> i_done one cycle after ack, i_rdata=32'h13, d_done stays 0, busy 0 after RESP.
- D write d_addr=32'h100, d_be=4'b0011, d_wdata=32'hDEAD_BEEF, ack after 1 cycle -> mem_we=1, mem_be=4'b0011, mem fields match; d_done pulse; d_rdata unchanged.
- i_req and d_req held continuously, 4 transactions -> with ARB_ROUND_ROBIN_EN order D,I,D,I (last owner reset = I); without: D,D,D,D.
- No mem_ack, TIMEOUT=8 -> mem_req drops after 8 cycles; d_done=1 and err=1 same cycle; next transaction proceeds normally.
- rst pulled low while BUSY with ack pending -> mem_req and busy 0 immediately, no done pulse; after release, a fresh i_req completes normally.
